fft_sequencer: RTL and testbench
================================

Name: fft_sequencer

Overview:
Controller that drives one butterfly unit through a complete in-place 64-point radix-2 decimation-in-frequency FFT: 6 stages of 32 butterflies each.
Generates the dual-port read addresses, the 5-bit bfpcontrol twiddle select and the delayed write-back addresses and enable, aligned to the butterfly pipeline.
Sits between the top-level FFT control (start/done handshake) and the data RAM plus butterfly datapath.

Parameters:
MEM_RD_LATENCY, 1, cycles from rd_en/rd_addr to read_data valid at butterfly input
BF_LATENCY, 3, cycles from butterfly input to valid write_data_a/b (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to run a full FFT; accepted only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final write of stage 5
stage  output  3  current issue stage 0..5
rd_en  output  1  read strobe for both RAM ports
rd_addr_a  output  6  upper butterfly input address
rd_addr_b  output  6  lower butterfly input address
bfpcontrol  output  5  twiddle select to butterfly, aligned to read data
wr_en  output  1  write strobe for both RAM ports
wr_addr_a  output  6  write address for write_data_a
wr_addr_b  output  6  write address for write_data_b

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output is 0. The delay lines are cleared, so no stale wr_en appears after release. Reset mid-run aborts the run with no done pulse.
- L = MEM_RD_LATENCY + BF_LATENCY.
- States:
  - IDLE: start=1 moves to RUN with stage=0, j=0.
  - RUN: issues one butterfly per cycle, j=0..31. After j=31 moves to DRAIN.
  - DRAIN: L cycles with rd_en=0. Then stage<5 moves to RUN with stage+1, j=0; stage=5 moves to FLUSH_DONE.
  - FLUSH_DONE: done=1 for one cycle, busy=0, returns to IDLE.
- start in any state other than IDLE is ignored.
- Issue arithmetic for stage s and counter j:
  - span = 32>>s; i = j mod span; group = j / span.
  - rd_addr_a = group*2*span + i; rd_addr_b = rd_addr_a + span.
  - Twiddle exponent k = (i<<s) mod 32.
  - bfpcontrol = {k[2:0], k[4:3]}: the low three bits select W0..W7 in the first rotator, the high two bits select none/W8/W16/W24 in the second.
- Alignment:
  - bfpcontrol is rd-side k delayed by MEM_RD_LATENCY, and is held 0 when not valid.
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly L cycles.
- The DRAIN gap guarantees that the first read of stage s+1 occurs one cycle after the last write of stage s. The RAM is write-before-read across cycles; there is no same-cycle read/write of one address.
- Timing:
  - First rd_en is the cycle after start is accepted.
  - Stage period is 32+L cycles.
  - The last wr_en is at cycle 6*(32+L) relative to the first rd_en at cycle 1; done follows one cycle later.
  - With defaults: 216 and 217.
- busy is high exactly while state is not IDLE or FLUSH_DONE.
- stage changes only when entering RUN.

Decomposition:
- Package fft_pkg:
  - constants FFT_N=64, FFT_LOG2N=6, BF_PER_STAGE=32;
  - state enum IDLE/RUN/DRAIN/FLUSH_DONE;
  - function tw_to_bfpcontrol(k[4:0]).
- Sub-module fft_delay_line: parameterised WIDTH and DEPTH shift register with async active-low clear. It is instantiated for bfpcontrol (depth MEM_RD_LATENCY) and for {rd_en, rd_addr_a, rd_addr_b} (depth L). DEPTH=0 is a pass-through.

Test Plan:
- Reset held low while start pulses, then released -> every output 0, no rd_en or wr_en, busy=0.
- start, defaults, observe stage 0 -> j=5: rd_addr_a=5, rd_addr_b=37, bfpcontrol one cycle later=5'b10100. j=13: addresses 13/45, bfpcontrol=5'b10101.
- Stage 1 j=20 -> rd_addr_a=36, rd_addr_b=52, bfpcontrol=5'b00001. Stage 5 j=7 -> 14/15, bfpcontrol=5'b00000.
- Full run with defaults -> 192 rd_en cycles, 4-cycle rd_en gaps between stages, each wr_en exactly 4 cycles after its read with identical addresses. Last wr_en at cycle 216, done pulse at 217, busy low at 217.
- start pulsed during RUN and DRAIN -> ignored, sequence unchanged. start in the cycle after done -> new run begins.
- reset asserted at stage 3, j=10 -> wr_en drops immediately, no done pulse. A later start runs the full 217-cycle sequence.
- Bench also repeated with MEM_RD_LATENCY=2, BF_LATENCY=4.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and twiddle mapping
// for the 64-point radix-2 DIF FFT sequencer.
package fft_pkg;

   localparam int FFT_N        = 64;
   localparam int FFT_LOG2N    = 6;
   localparam int BF_PER_STAGE = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FLUSH_DONE
   } fft_state_e;

   // Low three bits drive the W0..W7 rotator, high two the W0/8/16/24 one
   function automatic logic [4:0] tw_to_bfpcontrol(input logic [4:0] k);
      return {k[2:0], k[4:3]};
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with async active-low clear.
// DEPTH=0 degenerates to a wire.
module fft_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign q_o = d_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] pipe_q [DEPTH];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
            end else begin
               pipe_q[0] <= d_i;
               for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
            end
         end

         assign q_o = pipe_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/fft_sequencer.sv
// Address, twiddle and write-back sequencer driving one
// butterfly through a full in-place 64-point DIF FFT.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int MEM_RD_LATENCY = 1,
   parameter int BF_LATENCY     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [2:0] stage,
   output logic       rd_en,
   output logic [5:0] rd_addr_a,
   output logic [5:0] rd_addr_b,
   output logic [4:0] bfpcontrol,
   output logic       wr_en,
   output logic [5:0] wr_addr_a,
   output logic [5:0] wr_addr_b
);

   localparam int         L          = MEM_RD_LATENCY + BF_LATENCY;
   localparam logic [7:0] DRAIN_LAST = 8'(L - 1);
   localparam logic [2:0] LAST_STAGE = 3'(FFT_LOG2N - 1);
   localparam logic [4:0] LAST_BF    = 5'(BF_PER_STAGE - 1);

   fft_state_e state_q, state_d;
   logic [2:0] stage_q, stage_d;
   logic [4:0] j_q, j_d;
   logic [7:0] dcnt_q, dcnt_d;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      j_d     = j_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               stage_d = '0;
               j_d     = '0;
            end
         end
         RUN: begin
            j_d = j_q + 5'd1;
            if (j_q == LAST_BF) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end
         end
         DRAIN: begin
            dcnt_d = dcnt_q + 8'd1;
            if (dcnt_q == DRAIN_LAST) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = FLUSH_DONE;
               end else begin
                  state_d = RUN;
                  stage_d = stage_q + 3'd1;
                  j_d     = '0;
               end
            end
         end
         FLUSH_DONE: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         stage_q <= '0;
         j_q     <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         j_q     <= j_d;
         dcnt_q  <= dcnt_d;
      end
   end

   logic       iss;
   logic [5:0] span, mask, jx, addr_a;
   logic [4:0] k, bfp_rd;

   // Address a is j with a zero bit inserted at the span position
   assign iss    = (state_q == RUN);
   assign span   = 6'(FFT_N / 2) >> stage_q;
   assign mask   = span - 6'd1;
   assign jx     = {1'b0, j_q};
   assign addr_a = ((jx & ~mask) << 1) | (jx & mask);
   assign k      = j_q << stage_q;
   assign bfp_rd = iss ? tw_to_bfpcontrol(k) : '0;

   assign rd_en     = iss;
   assign rd_addr_a = iss ? addr_a : '0;
   assign rd_addr_b = iss ? (addr_a | span) : '0;

   fft_delay_line #(
      .WIDTH (5),
      .DEPTH (MEM_RD_LATENCY)
   ) u_bfp_dly (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (bfp_rd),
      .q_o    (bfpcontrol)
   );

   logic [12:0] wr_bus;

   fft_delay_line #(
      .WIDTH (13),
      .DEPTH (L)
   ) u_wr_dly (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    ({rd_en, rd_addr_a, rd_addr_b}),
      .q_o    (wr_bus)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = wr_bus;

   assign busy  = (state_q == RUN) || (state_q == DRAIN);
   assign done  = (state_q == FLUSH_DONE);
   assign stage = stage_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: default latencies
// on dut0, MEM_RD_LATENCY=2 / BF_LATENCY=4 on dut1.
module tb_fft_sequencer;

   localparam int MRL0 = 1;
   localparam int BFL0 = 3;
   localparam int MRL1 = 2;
   localparam int BFL1 = 4;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic [2:0] stage;
      logic       rd_en;
      logic [5:0] ra;
      logic [5:0] rb;
      logic [4:0] bfp;
      logic       wr_en;
      logic [5:0] wa;
      logic [5:0] wb;
   } vec_t;

   typedef struct packed {
      logic [2:0] s;
      logic [4:0] j;
      logic [5:0] a;
      logic [5:0] b;
      logic [4:0] bfp;
   } dir_t;

   dir_t dir_tab [7] = '{
      '{3'd0, 5'd5,  6'd5,  6'd37, 5'b10100},
      '{3'd0, 5'd13, 6'd13, 6'd45, 5'b10101},
      '{3'd1, 5'd20, 6'd36, 6'd52, 5'b00001},
      '{3'd2, 5'd9,  6'd17, 6'd25, 5'b10000},
      '{3'd3, 5'd3,  6'd3,  6'd7,  5'b00011},
      '{3'd4, 5'd31, 6'd61, 6'd63, 5'b00010},
      '{3'd5, 5'd7,  6'd14, 6'd15, 5'b00000}
   };

   logic clk = 1'b0;
   logic reset, start0, start1;

   logic       busy0, done0, rd_en0, wr_en0;
   logic [2:0] stage0;
   logic [5:0] ra0, rb0, wa0, wb0;
   logic [4:0] bfp0;
   logic       busy1, done1, rd_en1, wr_en1;
   logic [2:0] stage1;
   logic [5:0] ra1, rb1, wa1, wb1;
   logic [4:0] bfp1;

   vec_t o0, o1;
   vec_t q0 [$];
   vec_t q1 [$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   fft_sequencer #(
      .MEM_RD_LATENCY (MRL0),
      .BF_LATENCY     (BFL0)
   ) dut0 (
      .clk        (clk),
      .reset      (reset),
      .start      (start0),
      .busy       (busy0),
      .done       (done0),
      .stage      (stage0),
      .rd_en      (rd_en0),
      .rd_addr_a  (ra0),
      .rd_addr_b  (rb0),
      .bfpcontrol (bfp0),
      .wr_en      (wr_en0),
      .wr_addr_a  (wa0),
      .wr_addr_b  (wb0)
   );

   fft_sequencer #(
      .MEM_RD_LATENCY (MRL1),
      .BF_LATENCY     (BFL1)
   ) dut1 (
      .clk        (clk),
      .reset      (reset),
      .start      (start1),
      .busy       (busy1),
      .done       (done1),
      .stage      (stage1),
      .rd_en      (rd_en1),
      .rd_addr_a  (ra1),
      .rd_addr_b  (rb1),
      .bfpcontrol (bfp1),
      .wr_en      (wr_en1),
      .wr_addr_a  (wa1),
      .wr_addr_b  (wb1)
   );

   assign o0 = {busy0, done0, stage0, rd_en0, ra0, rb0,
                bfp0, wr_en0, wa0, wb0};
   assign o1 = {busy1, done1, stage1, rd_en1, ra1, rb1,
                bfp1, wr_en1, wa1, wb1};

   task automatic chk(input string nm,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  nm, got, exp, $time);
      end
   endtask

   // Read issued at cycle c (start accepted at cycle 0)
   function automatic void rd_at(input int c, input int l,
                                 output logic en,
                                 output logic [5:0] a,
                                 output logic [5:0] b,
                                 output logic [4:0] k);
      int p, s, j, span, i, g;
      p  = 32 + l;
      en = 1'b0;
      a  = '0;
      b  = '0;
      k  = '0;
      if (c >= 1) begin
         s = (c - 1) / p;
         j = (c - 1) % p;
         if (s < 6 && j < 32) begin
            span = 32 >> s;
            i    = j % span;
            g    = j / span;
            en   = 1'b1;
            a    = 6'(g * 2 * span + i);
            b    = 6'(g * 2 * span + i + span);
            k    = 5'((i << s) % 32);
         end
      end
   endfunction

   function automatic vec_t model(input int c,
                                  input logic [2:0] prev,
                                  input int mrl, input int l);
      vec_t       v;
      logic       en;
      logic [5:0] a, b;
      logic [4:0] k;
      int         p;
      p = 32 + l;
      v = '0;
      rd_at(c, l, en, a, b, k);
      v.rd_en = en;
      v.ra    = a;
      v.rb    = b;
      rd_at(c - mrl, l, en, a, b, k);
      v.bfp   = en ? {k[2:0], k[4:3]} : 5'd0;
      rd_at(c - l, l, en, a, b, k);
      v.wr_en = en;
      v.wa    = a;
      v.wb    = b;
      v.busy  = (c >= 1 && c <= 6 * p);
      v.done  = (c == 6 * p + 1);
      if (c == 0)          v.stage = prev;
      else if (c <= 6 * p) v.stage = 3'((c - 1) / p);
      else                 v.stage = 3'd5;
      return v;
   endfunction

   function automatic vec_t obs_of(input int d);
      return (d == 0) ? o0 : o1;
   endfunction

   task automatic push(input int d, input vec_t v);
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
   endtask

   task automatic set_start(input int d, input logic v);
      if (d == 0) start0 = v;
      else        start1 = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mon(input int d, input vec_t g);
      vec_t e;
      vec_t gi;
      int   n;
      n = (d == 0) ? q0.size() : q1.size();
      if (!reset) begin
         chk("reset_outputs", g, '0);
      end else if (n > 0) begin
         e = (d == 0) ? q0.pop_front() : q1.pop_front();
         chk((d == 0) ? "dut0_cycle" : "dut1_cycle", g, e);
      end else begin
         gi       = g;
         gi.stage = '0;
         chk((d == 0) ? "dut0_idle" : "dut1_idle", gi, '0);
      end
   endtask

   always @(negedge clk) begin
      mon(0, o0);
      mon(1, o1);
   end

   task automatic directed(input int c, input int mrl,
                           input int l, input vec_t g);
      int p;
      int rc;
      p = 32 + l;
      foreach (dir_tab[n]) begin
         rc = 1 + int'(dir_tab[n].s) * p + int'(dir_tab[n].j);
         if (c == rc) begin
            chk("dir_rd_en", g.rd_en, 1);
            chk("dir_rd_a", g.ra, dir_tab[n].a);
            chk("dir_rd_b", g.rb, dir_tab[n].b);
         end
         if (c == rc + mrl)
            chk("dir_bfp", g.bfp, dir_tab[n].bfp);
         if (c == rc + l) begin
            chk("dir_wr_en", g.wr_en, 1);
            chk("dir_wr_a", g.wa, dir_tab[n].a);
            chk("dir_wr_b", g.wb, dir_tab[n].b);
         end
      end
   endtask

   task automatic abort_run(input int d, input vec_t pre);
      vec_t g;
      chk("abort_pre_wr_en", pre.wr_en, 1);
      #5;
      reset = 1'b0;
      q0.delete();
      q1.delete();
      #1;
      g = obs_of(d);
      chk("abort_wr_en", g.wr_en, 0);
      chk("abort_rd_en", g.rd_en, 0);
      chk("abort_busy", g.busy, 0);
      chk("abort_done", g.done, 0);
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic run(input int d, input logic [2:0] prev,
                      input bit inject, input int abort_c);
      int   mrl, l, p, rdn, wrn, lastwr, donec;
      vec_t g;
      mrl    = (d == 0) ? MRL0 : MRL1;
      l      = (d == 0) ? MRL0 + BFL0 : MRL1 + BFL1;
      p      = 32 + l;
      rdn    = 0;
      wrn    = 0;
      lastwr = -1;
      donec  = -1;
      for (int c = 0; c <= 6 * p + 1; c++)
         push(d, model(c, prev, mrl, l));
      set_start(d, 1'b1);
      step();
      set_start(d, 1'b0);
      for (int c = 1; c <= 6 * p + 1; c++) begin
         g = obs_of(d);
         if (g.rd_en) rdn++;
         if (g.wr_en) begin
            wrn++;
            lastwr = c;
         end
         if (g.done) donec = c;
         if (d == 0) directed(c, mrl, l, g);
         if (c == abort_c) begin
            abort_run(d, g);
            return;
         end
         if (inject && (c == 20 || c == 34)) set_start(d, 1'b1);
         step();
         set_start(d, 1'b0);
      end
      chk("rd_count", rdn, 192);
      chk("wr_count", wrn, 192);
      chk("last_wr_cycle", lastwr, 6 * p);
      chk("done_cycle", donec, 6 * p + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      #1 reset = 1'b0;
      repeat (3) begin
         step();
         start0 = ~start0;
         start1 = ~start1;
      end
      step();
      start0 = 1'b0;
      start1 = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("post_reset_dut0", o0, '0);
      chk("post_reset_dut1", o1, '0);
      repeat (3) step();

      run(0, 3'd0, 1'b1, -1);
      run(0, 3'd5, 1'b0, 1 + 3 * (32 + MRL0 + BFL0) + 10);
      repeat (3) step();
      run(0, 3'd0, 1'b0, -1);
      repeat (3) step();
      run(1, 3'd0, 1'b0, -1);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
